// File: rtl/uart_rx_async_core.sv
// uart_rx_async_core: 16x-oversampled UART receiver with 3-sample majority filter,
// parity/framing checks and delivery to a holding register or an external FIFO.
module uart_rx_async_core #(
  parameter int RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_errors,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       fifo_write_rx,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  rx_state_t  r_state, w_state_next;
  logic       r_rx_meta, r_rx_sync;
  logic [2:0] r_samp;
  logic       r_line_seen_high;
  logic [3:0] r_samp_cnt, w_samp_cnt_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_deliver_pend;
  logic       w_filt, w_set_parity, w_set_framing, w_stop_done;
  logic       w_accept, w_overflow_set;
  logic [7:0] w_data;
  logic [2:0] w_last_bit;

  assign w_filt     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  // Bits enter at the MSB, so a 7-bit byte sits in [7:1] and is shifted down here.
  assign w_data     = bit8 ? r_shift : {1'b0, r_shift[7:1]};
  assign w_last_bit = bit8 ? 3'd7 : 3'd6;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_samp    <= 3'b111;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      if (baud_clock) r_samp <= {r_samp[1:0], r_rx_sync};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= RX_IDLE;
      r_samp_cnt       <= 4'd0;
      r_bit_cnt        <= 3'd0;
      r_shift          <= 8'd0;
      r_line_seen_high <= 1'b0;
      r_deliver_pend   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_samp_cnt     <= w_samp_cnt_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_shift        <= w_shift_next;
      r_deliver_pend <= w_stop_done;
      // Only an idle-high line arms start detection, so a stuck-low line cannot retrigger.
      if (baud_clock && r_state == RX_IDLE) r_line_seen_high <= w_filt;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_samp_cnt_next = r_samp_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_set_parity    = 1'b0;
    w_set_framing   = 1'b0;
    w_stop_done     = 1'b0;
    if (baud_clock) begin
      case (r_state)
        RX_IDLE: begin
          w_samp_cnt_next = 4'd0;
          w_bit_cnt_next  = 3'd0;
          if (!w_filt && r_line_seen_high) w_state_next = RX_START;
        end
        RX_START: begin
          if (r_samp_cnt == 4'd7) begin
            w_samp_cnt_next = 4'd0;
            w_state_next    = w_filt ? RX_IDLE : RX_DATA;
          end else begin
            w_samp_cnt_next = r_samp_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          w_samp_cnt_next = r_samp_cnt + 4'd1;
          if (r_samp_cnt == 4'd15) begin
            w_shift_next = {w_filt, r_shift[7:1]};
            if (r_bit_cnt == w_last_bit) begin
              w_bit_cnt_next = 3'd0;
              w_state_next   = parity_en ? RX_PARITY : RX_STOP;
            end else begin
              w_bit_cnt_next = r_bit_cnt + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          w_samp_cnt_next = r_samp_cnt + 4'd1;
          if (r_samp_cnt == 4'd15) begin
            w_set_parity = (w_filt != (odd_n_even ^ (^w_data)));
            w_state_next = RX_STOP;
          end
        end
        RX_STOP: begin
          w_samp_cnt_next = r_samp_cnt + 4'd1;
          if (r_samp_cnt == 4'd15) begin
            w_set_framing = !w_filt;
            w_stop_done   = 1'b1;
            w_state_next  = RX_IDLE;
          end
        end
        default: w_state_next = RX_IDLE;
      endcase
    end
  end

  assign w_accept       = r_deliver_pend && ((RX_FIFO != 0) ? !fifo_full : (!rx_ready || read_rx_byte));
  assign w_overflow_set = r_deliver_pend && !w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte       <= 8'd0;
      rx_ready      <= 1'b0;
      fifo_write_rx <= 1'b1;
      parity_err    <= 1'b0;
      framing_err   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // A new error in the same clk as clear_errors keeps its flag set.
      parity_err    <= w_set_parity | (parity_err & ~clear_errors);
      framing_err   <= w_set_framing | (framing_err & ~clear_errors);
      overflow      <= w_overflow_set | (overflow & ~clear_errors);
      fifo_write_rx <= 1'b1;
      if (w_accept) rx_byte <= w_data;
      if (RX_FIFO != 0) begin
        rx_ready <= 1'b0;
        if (w_accept) fifo_write_rx <= 1'b0;
      end else if (w_accept) begin
        rx_ready <= 1'b1;
      end else if (read_rx_byte) begin
        rx_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_async_core.sv
// Bench for uart_rx_async_core: both delivery modes receive the same line; a frame-level
// model predicts bytes, handshake and sticky flags from the frame contents.
module tb_uart_rx_async_core;
  logic clk = 1'b0;
  logic reset, baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte, clear_errors, fifo_full;
  logic [7:0] rx_byte0, rx_byte1;
  logic ready0, ready1, fwr0, fwr1, pe0, pe1, fe0, fe1, ov0, ov1;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0, last_start = 0, off8 = 0;
  int strobe_cnt = 0, fwr0_low = 0, m_strobes = 0;
  logic [7:0] last_strobe = 8'd0;
  logic prev_ready0 = 1'b0;
  logic [7:0] m_byte0 = 0, m_byte1 = 0, m_last_strobe = 0;
  bit m_ready0 = 0, m_ov0 = 0, m_ov1 = 0, m_pe = 0, m_fe = 0;

  uart_rx_async_core #(.RX_FIFO(0)) dut0 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_errors(clear_errors), .fifo_full(fifo_full), .rx_byte(rx_byte0), .rx_ready(ready0),
    .fifo_write_rx(fwr0), .parity_err(pe0), .framing_err(fe0), .overflow(ov0));

  uart_rx_async_core #(.RX_FIFO(1)) dut1 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_errors(clear_errors), .fifo_full(fifo_full), .rx_byte(rx_byte1), .rx_ready(ready1),
    .fifo_write_rx(fwr1), .parity_err(pe1), .framing_err(fe1), .overflow(ov1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 16x baud enable: one clk in every four.
  initial begin
    baud_clock = 1'b0;
    forever begin
      @(negedge clk);
      baud_clock = (cyc % 4 == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready0 && !prev_ready0) rise_cyc = cyc;
      prev_ready0 = ready0;
      if (fwr1 === 1'b0) begin
        strobe_cnt++;
        last_strobe = rx_byte1;
      end
      if (fwr0 !== 1'b1) fwr0_low++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rx_byte0"}, 32'(rx_byte0), 32'(m_byte0));
    check({tag, ".rx_ready0"}, 32'(ready0), 32'(m_ready0));
    check({tag, ".overflow0"}, 32'(ov0), 32'(m_ov0));
    check({tag, ".parity_err0"}, 32'(pe0), 32'(m_pe));
    check({tag, ".framing_err0"}, 32'(fe0), 32'(m_fe));
    check({tag, ".rx_byte1"}, 32'(rx_byte1), 32'(m_byte1));
    check({tag, ".rx_ready1"}, 32'(ready1), 32'd0);
    check({tag, ".overflow1"}, 32'(ov1), 32'(m_ov1));
    check({tag, ".parity_err1"}, 32'(pe1), 32'(m_pe));
    check({tag, ".framing_err1"}, 32'(fe1), 32'(m_fe));
    check({tag, ".fifo_write_rx1"}, 32'(fwr1), 32'd1);
    check({tag, ".strobe_count"}, 32'(strobe_cnt), 32'(m_strobes));
    check({tag, ".strobe_byte"}, 32'(last_strobe), 32'(m_last_strobe));
    check({tag, ".fifo_write_rx0_low"}, 32'(fwr0_low), 32'd0);
  endtask

  task automatic do_read();
    @(negedge clk); read_rx_byte = 1'b1;
    @(negedge clk); read_rx_byte = 1'b0;
    m_ready0 = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear_errors = 1'b1;
    @(negedge clk); clear_errors = 1'b0;
    m_pe = 0; m_fe = 0; m_ov0 = 0; m_ov1 = 0;
  endtask

  // Offsets are clk counts from the start-bit edge to the clk edge where the pulse must land.
  task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen, input bit odd,
                            input bit bad_par, input bit bad_stop, input bit glitch,
                            input int read_off, input int clr_off, input int rst_bit);
    logic [7:0] dm;
    bit pbit, aborted;
    int nb, st;
    aborted = 0;
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    dm = b8 ? data : {1'b0, data[6:0]};
    nb = b8 ? 8 : 7;
    pbit = odd ^ (^dm) ^ bad_par;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    st = cyc;
    last_start = st;
    fork
      begin
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
          rx = dm[i];
          if (i == rst_bit) begin
            repeat (32) @(negedge clk);
            reset = 1'b1; rx = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            aborted = 1;
            break;
          end else if (glitch && i == 3) begin
            repeat (32) @(negedge clk);
            rx = ~dm[i];
            repeat (4) @(negedge clk);
            rx = dm[i];
            repeat (28) @(negedge clk);
          end else begin
            repeat (64) @(negedge clk);
          end
        end
        if (!aborted) begin
          if (pen) begin
            rx = pbit;
            repeat (64) @(negedge clk);
          end
          rx = !bad_stop;
          repeat (64) @(negedge clk);
        end
        rx = 1'b1;
        repeat (192) @(negedge clk);
      end
      begin
        if (read_off >= 0) begin
          while (cyc < st + read_off - 1) @(negedge clk);
          read_rx_byte = 1'b1;
          @(negedge clk);
          read_rx_byte = 1'b0;
        end
      end
      begin
        if (clr_off >= 0) begin
          while (cyc < st + clr_off - 1) @(negedge clk);
          clear_errors = 1'b1;
          @(negedge clk);
          clear_errors = 1'b0;
        end
      end
    join
    if (aborted) begin
      m_byte0 = 0; m_ready0 = 0; m_ov0 = 0; m_byte1 = 0; m_ov1 = 0; m_pe = 0; m_fe = 0;
    end else begin
      if (clr_off >= 0) begin
        m_pe = 0; m_fe = 0; m_ov0 = 0; m_ov1 = 0;
      end
      if (pen && bad_par && clr_off < 0) m_pe = 1;
      if (bad_stop) m_fe = 1;
      if (!m_ready0 || read_off >= 0) begin
        m_byte0 = dm; m_ready0 = 1;
      end else begin
        m_ov0 = 1;
      end
      if (!fifo_full) begin
        m_byte1 = dm; m_strobes++; m_last_strobe = dm;
      end else begin
        m_ov1 = 1;
      end
    end
    $display("[TB] frame data=%02h bits=%0d par_en=%0d odd=%0d bad_par=%0d bad_stop=%0d full=%0d rst_bit=%0d",
             data, nb, pen, odd, bad_par, bad_stop, fifo_full, rst_bit);
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0; clear_errors = 1'b0; fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    repeat (32) @(negedge clk);

    // 8N1 0xA5, then consume it
    send_frame(8'hA5, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    off8 = rise_cyc - last_start;
    check_all("8n1_a5");
    do_read();
    check_all("8n1_read");

    // 7O1: correct parity, then wrong parity
    do_read();
    send_frame(8'h35, 0, 1, 1, 0, 0, 0, -1, -1, -1);
    check_all("7o1_good");
    do_read();
    send_frame(8'h35, 0, 1, 1, 1, 0, 0, -1, -1, -1);
    check_all("7o1_bad");
    do_clear();
    do_read();

    // Short low pulse must not start a frame
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (192) @(negedge clk);
    $display("[TB] short low pulse of 5 baud ticks");
    check_all("short_pulse");

    // Single-sample glitch inside a data bit
    send_frame(8'h96, 1, 0, 0, 0, 0, 1, -1, -1, -1);
    check_all("glitch");
    do_read();

    // Framing error, clear, then clear colliding with a new framing error
    send_frame(8'h3C, 1, 0, 0, 0, 1, 0, -1, -1, -1);
    check_all("framing");
    do_clear();
    check_all("framing_clr");
    do_read();
    send_frame(8'h3C, 1, 0, 0, 0, 1, 0, -1, off8 - 1, -1);
    check_all("framing_clr_collide");
    do_read();
    do_clear();

    // Overflow without read, then read landing on the delivery clk
    send_frame(8'h11, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    send_frame(8'h22, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    check_all("overflow");
    do_clear();
    send_frame(8'h22, 1, 0, 0, 0, 0, 0, off8, -1, -1);
    check_all("read_at_delivery");

    // FIFO full overflow, then reset in the middle of a frame
    fifo_full = 1'b1;
    send_frame(8'h5A, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    check_all("fifo_full");
    fifo_full = 1'b0;
    send_frame(8'h5A, 1, 0, 0, 0, 0, 0, -1, -1, 4);
    check_all("reset_mid_frame");
    send_frame(8'hC3, 1, 1, 0, 0, 0, 0, -1, -1, -1);
    check_all("after_reset");

    // Randomized frames
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      bit rb8, rpen, rodd, rbp, rbs;
      d = 8'($urandom);
      rb8 = 1'($urandom % 2); rpen = 1'($urandom % 2); rodd = 1'($urandom % 2);
      rbp = ($urandom % 4 == 0); rbs = ($urandom % 8 == 0);
      fifo_full = ($urandom % 4 == 0);
      if ($urandom % 2 == 1) do_read();
      if ($urandom % 4 == 0) do_clear();
      send_frame(d, rb8, rpen, rodd, rbp, rbs, 0, -1, -1, -1);
      check_all("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
